// File: rtl/bp_unicore_l2_dma_mux_if.sv
// DMA bus between the L2 bank array, the bank-to-DRAM mux and the top-level DRAM DMA port.
// The slave modport is the mux view; master is the view of whatever surrounds it.
interface bp_unicore_l2_dma_mux_if #(
  parameter int num_banks_p  = 2,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64
);
  localparam int pkt_width_lp = 1 + addr_width_p;

  // Handshakes: v/ready transfers when both are high in a cycle; v/yumi means the consumer
  // asserts yumi only while v is high, and the transfer happens in that same cycle.
  logic [num_banks_p*pkt_width_lp-1:0] bank_dma_pkt_i;
  logic [num_banks_p-1:0]              bank_dma_pkt_v_i;
  logic [num_banks_p-1:0]              bank_dma_pkt_yumi_o;
  logic [num_banks_p*data_width_p-1:0] bank_dma_data_o;
  logic [num_banks_p-1:0]              bank_dma_data_v_o;
  logic [num_banks_p-1:0]              bank_dma_data_ready_and_i;
  logic [num_banks_p*data_width_p-1:0] bank_dma_data_i;
  logic [num_banks_p-1:0]              bank_dma_data_v_i;
  logic [num_banks_p-1:0]              bank_dma_data_yumi_o;
  logic [pkt_width_lp-1:0]             dma_pkt_o;
  logic                                dma_pkt_v_o;
  logic                                dma_pkt_yumi_i;
  logic [data_width_p-1:0]             dma_data_i;
  logic                                dma_data_v_i;
  logic                                dma_data_ready_and_o;
  logic [data_width_p-1:0]             dma_data_o;
  logic                                dma_data_v_o;
  logic                                dma_data_yumi_i;
  logic                                dbg_arb_state_o;

  modport slave (
    input  bank_dma_pkt_i, bank_dma_pkt_v_i, bank_dma_data_ready_and_i, bank_dma_data_i,
           bank_dma_data_v_i, dma_pkt_yumi_i, dma_data_i, dma_data_v_i, dma_data_yumi_i,
    output bank_dma_pkt_yumi_o, bank_dma_data_o, bank_dma_data_v_o, bank_dma_data_yumi_o,
           dma_pkt_o, dma_pkt_v_o, dma_data_ready_and_o, dma_data_o, dma_data_v_o,
           dbg_arb_state_o
  );

  modport master (
    output bank_dma_pkt_i, bank_dma_pkt_v_i, bank_dma_data_ready_and_i, bank_dma_data_i,
           bank_dma_data_v_i, dma_pkt_yumi_i, dma_data_i, dma_data_v_i, dma_data_yumi_i,
    input  bank_dma_pkt_yumi_o, bank_dma_data_o, bank_dma_data_v_o, bank_dma_data_yumi_o,
           dma_pkt_o, dma_pkt_v_o, dma_data_ready_and_o, dma_data_o, dma_data_v_o,
           dbg_arb_state_o
  );
endinterface

// File: rtl/bp_unicore_l2_dma_mux.sv
// Merges the DMA ports of several L2 banks onto one DRAM DMA port: round-robin packet
// arbitration, in-order fill routing by read-tag FIFO, eviction streaming by write-tag FIFO.
module bp_unicore_l2_dma_mux #(
  parameter int num_banks_p       = 2,
  parameter int addr_width_p      = 28,
  parameter int data_width_p      = 64,
  parameter int block_width_p     = 512,
  parameter int max_outstanding_p = 4
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bp_unicore_l2_dma_mux_if.slave bus
);
  localparam int pkt_width_lp = 1 + addr_width_p;
  localparam int beats_lp     = block_width_p / data_width_p;
  localparam int id_w_lp      = (num_banks_p > 1) ? $clog2(num_banks_p) : 1;
  localparam int ptr_w_lp     = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp     = $clog2(max_outstanding_p + 1);
  localparam int beat_w_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  if ((block_width_p % data_width_p) != 0 || beats_lp < 1) begin : g_bad_cfg
    $error("block_width_p must be a positive multiple of data_width_p");
  end

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} arb_state_e;

  arb_state_e                r_state, w_state_n;
  logic [id_w_lp-1:0]        r_lock_bank, r_rr, w_pick, w_gnt;
  logic                      w_pick_v, w_gnt_v, w_accept;
  logic [pkt_width_lp-1:0]   w_pkt [num_banks_p];
  logic [num_banks_p-1:0]    w_elig;

  // Tag FIFO index 0 holds read (fill) tags, index 1 holds write (evict) tags.
  logic [id_w_lp-1:0]        r_mem  [2][max_outstanding_p];
  logic [ptr_w_lp-1:0]       r_wptr [2];
  logic [ptr_w_lp-1:0]       r_rptr [2];
  logic [cnt_w_lp-1:0]       r_cnt  [2];
  logic [beat_w_lp-1:0]      r_beat [2];
  logic [id_w_lp-1:0]        w_head [2];
  logic [1:0]                w_push, w_pop, w_xfer, w_full, w_empty;
  logic                      w_evict_v;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_comb begin
    for (int f = 0; f < 2; f++) begin
      w_full[f]  = (r_cnt[f] == cnt_w_lp'(max_outstanding_p));
      w_empty[f] = (r_cnt[f] == '0);
      w_head[f]  = r_mem[f][r_rptr[f]];
    end
  end

  // A bank is eligible only if the tag FIFO matching its packet type has room.
  always_comb begin
    for (int k = 0; k < num_banks_p; k++) begin
      w_pkt[k]  = bus.bank_dma_pkt_i[k*pkt_width_lp +: pkt_width_lp];
      w_elig[k] = bus.bank_dma_pkt_v_i[k] & ~w_full[w_pkt[k][pkt_width_lp-1]];
    end
  end

  always_comb begin
    w_pick   = '0;
    w_pick_v = 1'b0;
    for (int i = 0; i < num_banks_p; i++) begin
      if (!w_pick_v && w_elig[(int'(r_rr) + i) % num_banks_p]) begin
        w_pick_v = 1'b1;
        w_pick   = id_w_lp'((int'(r_rr) + i) % num_banks_p);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_UNLOCKED;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_UNLOCKED: if (w_pick_v && !bus.dma_pkt_yumi_i) w_state_n = ST_LOCKED;
      ST_LOCKED:   if (bus.dma_pkt_yumi_i)              w_state_n = ST_UNLOCKED;
      default:     w_state_n = ST_UNLOCKED;
    endcase
  end

  // Once locked the granted bank holds its packet, so eligibility is not re-evaluated.
  always_comb begin
    w_gnt    = (r_state == ST_LOCKED) ? r_lock_bank : w_pick;
    w_gnt_v  = ((r_state == ST_LOCKED) | w_pick_v) & ~reset_i;
    w_accept = w_gnt_v & bus.dma_pkt_yumi_i;
    bus.dma_pkt_v_o         = w_gnt_v;
    bus.dma_pkt_o           = w_pkt[w_gnt];
    bus.bank_dma_pkt_yumi_o = '0;
    if (w_accept) bus.bank_dma_pkt_yumi_o[w_gnt] = 1'b1;
    w_push[0] = w_accept & ~w_pkt[w_gnt][pkt_width_lp-1];
    w_push[1] = w_accept &  w_pkt[w_gnt][pkt_width_lp-1];
    bus.dbg_arb_state_o = r_state;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lock_bank <= '0;
      r_rr        <= '0;
    end else begin
      if (r_state == ST_UNLOCKED && w_pick_v) r_lock_bank <= w_pick;
      if (w_accept) r_rr <= (w_gnt == id_w_lp'(num_banks_p - 1)) ? '0 : w_gnt + id_w_lp'(1);
    end
  end

  // Fill beats are broadcast; only the bank at the read-FIFO head sees valid.
  always_comb begin
    bus.bank_dma_data_o      = {num_banks_p{bus.dma_data_i}};
    bus.dma_data_ready_and_o = ~w_empty[0] & bus.bank_dma_data_ready_and_i[w_head[0]] & ~reset_i;
    bus.bank_dma_data_v_o    = '0;
    if (!w_empty[0] && bus.dma_data_v_i && !reset_i) bus.bank_dma_data_v_o[w_head[0]] = 1'b1;
    w_xfer[0] = bus.dma_data_ready_and_o & bus.dma_data_v_i;

    w_evict_v        = ~w_empty[1] & bus.bank_dma_data_v_i[w_head[1]] & ~reset_i;
    bus.dma_data_v_o = w_evict_v;
    bus.dma_data_o   = bus.bank_dma_data_i[int'(w_head[1])*data_width_p +: data_width_p];
    bus.bank_dma_data_yumi_o = '0;
    if (w_evict_v && bus.dma_data_yumi_i) bus.bank_dma_data_yumi_o[w_head[1]] = 1'b1;
    w_xfer[1] = w_evict_v & bus.dma_data_yumi_i;
  end

  always_comb begin
    for (int f = 0; f < 2; f++) w_pop[f] = w_xfer[f] & (r_beat[f] == beat_w_lp'(beats_lp - 1));
  end

  always_ff @(posedge clk_i) begin
    for (int f = 0; f < 2; f++) begin
      if (reset_i) begin
        r_wptr[f] <= '0;
        r_rptr[f] <= '0;
        r_cnt[f]  <= '0;
        r_beat[f] <= '0;
      end else begin
        if (w_push[f]) begin
          r_mem[f][r_wptr[f]] <= w_gnt;
          r_wptr[f]           <= ptr_inc(r_wptr[f]);
        end
        if (w_pop[f]) r_rptr[f] <= ptr_inc(r_rptr[f]);
        unique case ({w_push[f], w_pop[f]})
          2'b10:   r_cnt[f] <= r_cnt[f] + cnt_w_lp'(1);
          2'b01:   r_cnt[f] <= r_cnt[f] - cnt_w_lp'(1);
          default: r_cnt[f] <= r_cnt[f];
        endcase
        if (w_xfer[f]) r_beat[f] <= w_pop[f] ? '0 : r_beat[f] + beat_w_lp'(1);
      end
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.dma_pkt_yumi_i |-> bus.dma_pkt_v_o)
    else $error("dma_pkt_yumi_i asserted without dma_pkt_v_o");

endmodule
